// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall sequencer for the IF/ID and ID/EX registers: load-use
// bubbles, memory-wait holds, taken-branch flushes, perf counters and timeout error.
module hazard_stall_ctrl #(
    parameter int REG_W       = 3,
    parameter int LD_LAT      = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             pc_sel_branch,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err_timeout
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [2:0]        LD_RELOAD = 3'(LD_LAT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_s, wait_next_s;
    logic [2:0]        ld_cnt_r, ld_cnt_s;
    logic              br_pend_r, br_pend_s;
    logic              err_r, err_s;
    logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;

    logic hazard_s, br_s, flush_apply_s;
    logic pc_en_s, pc_sel_s, ifid_en_s, ifid_flush_s;
    logic idex_en_s, idex_flush_s, exmem_en_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    assign hazard_s = id_valid & ex_mem_read &
                      ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    assign br_s     = branch_taken | br_pend_r;

    // Next-state and same-cycle pipeline controls; priority ERROR > busy > branch > load-use.
    always_comb begin
        state_s       = state_r;
        wait_cnt_s    = wait_cnt_r;
        wait_next_s   = WAIT_ONE;
        ld_cnt_s      = ld_cnt_r;
        br_pend_s     = br_pend_r;
        err_s         = err_r;
        flush_apply_s = 1'b0;
        pc_en_s       = 1'b1;
        pc_sel_s      = 1'b0;
        ifid_en_s     = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_en_s     = 1'b1;
        idex_flush_s  = 1'b0;
        exmem_en_s    = 1'b1;
        case (state_r)
            ST_RUN, ST_LD_STALL, ST_MEM_WAIT: begin
                if (mem_busy) begin
                    pc_en_s    = 1'b0;
                    ifid_en_s  = 1'b0;
                    idex_en_s  = 1'b0;
                    exmem_en_s = 1'b0;
                    br_pend_s  = br_pend_r | branch_taken;
                    ld_cnt_s   = 3'd0;
                    if (state_r == ST_MEM_WAIT) begin
                        wait_next_s = wait_cnt_r + WAIT_ONE;
                    end else begin
                        wait_next_s = WAIT_ONE;
                    end
                    wait_cnt_s = wait_next_s;
                    if (wait_next_s == WAIT_MAX) begin
                        err_s   = 1'b1;
                        state_s = ST_ERROR;
                    end else begin
                        state_s = ST_MEM_WAIT;
                    end
                end else if (br_s) begin
                    // The squashed ID instruction makes any coincident hazard moot.
                    pc_sel_s      = 1'b1;
                    ifid_flush_s  = 1'b1;
                    idex_flush_s  = 1'b1;
                    br_pend_s     = 1'b0;
                    ld_cnt_s      = 3'd0;
                    wait_cnt_s    = '0;
                    flush_apply_s = 1'b1;
                    state_s       = ST_RUN;
                end else if ((state_r == ST_LD_STALL) || hazard_s) begin
                    pc_en_s      = 1'b0;
                    ifid_en_s    = 1'b0;
                    idex_flush_s = 1'b1;
                    wait_cnt_s   = '0;
                    if (state_r == ST_LD_STALL) begin
                        ld_cnt_s = ld_cnt_r - 3'd1;
                        state_s  = (ld_cnt_s == 3'd0) ? ST_RUN : ST_LD_STALL;
                    end else if (LD_LAT > 1) begin
                        ld_cnt_s = LD_RELOAD;
                        state_s  = ST_LD_STALL;
                    end else begin
                        state_s  = ST_RUN;
                    end
                end else begin
                    wait_cnt_s = '0;
                    state_s    = ST_RUN;
                end
            end
            ST_ERROR: begin
                pc_en_s    = 1'b0;
                ifid_en_s  = 1'b0;
                idex_en_s  = 1'b0;
                exmem_en_s = 1'b0;
                state_s    = ST_ERROR;
            end
            default: begin
                pc_en_s    = 1'b0;
                ifid_en_s  = 1'b0;
                idex_en_s  = 1'b0;
                exmem_en_s = 1'b0;
                state_s    = ST_RUN;
            end
        endcase
    end

    // State, counters and sticky error; everything clears on reset, including a pending branch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_RUN;
            wait_cnt_r  <= '0;
            ld_cnt_r    <= 3'd0;
            br_pend_r   <= 1'b0;
            err_r       <= 1'b0;
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            ld_cnt_r   <= ld_cnt_s;
            br_pend_r  <= br_pend_s;
            err_r      <= err_s;
            if (!pc_en_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_apply_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    // Controls are forced inactive for as long as reset is held.
    assign pc_en         = rst & pc_en_s;
    assign pc_sel_branch = rst & pc_sel_s;
    assign ifid_en       = rst & ifid_en_s;
    assign ifid_flush    = rst & ifid_flush_s;
    assign idex_en       = rst & idex_en_s;
    assign idex_flush    = rst & idex_flush_s;
    assign exmem_en      = rst & exmem_en_s;
    assign stall_cnt     = stall_cnt_r;
    assign flush_cnt     = flush_cnt_r;
    assign err_timeout   = err_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two parameterisations share stimulus; a behavioural
// model checks every cycle, directed sequences pin literal values.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_uses_rs2, ex_mem_read, branch_taken, mem_busy;
    logic [2:0] id_rs1, id_rs2, ex_rd;
    logic       pc_en[2], pc_sel[2], ifid_en[2], ifid_flush[2];
    logic       idex_en[2], idex_flush[2], exmem_en[2], err[2];
    logic [15:0] stall_a, flush_a;
    logic [3:0]  stall_b, flush_b;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_left = 0;

    // Behavioural model: consecutive busy count, extra bubbles still owed, pending branch.
    bit m_err[2], m_brp[2];
    int m_busy[2], m_left[2], m_stall[2], m_flush[2];
    int lat, to, mx, act_stall, act_flush;
    logic [6:0] exp_o, act_o;
    bit hz, br_now;

    hazard_stall_ctrl #(.REG_W(3), .LD_LAT(1), .MEM_TIMEOUT(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en[0]), .pc_sel_branch(pc_sel[0]), .ifid_en(ifid_en[0]),
        .ifid_flush(ifid_flush[0]), .idex_en(idex_en[0]), .idex_flush(idex_flush[0]),
        .exmem_en(exmem_en[0]), .stall_cnt(stall_a), .flush_cnt(flush_a),
        .err_timeout(err[0]));

    hazard_stall_ctrl #(.REG_W(3), .LD_LAT(3), .MEM_TIMEOUT(5), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en[1]), .pc_sel_branch(pc_sel[1]), .ifid_en(ifid_en[1]),
        .ifid_flush(ifid_flush[1]), .idex_en(idex_en[1]), .idex_flush(idex_flush[1]),
        .exmem_en(exmem_en[1]), .stall_cnt(stall_b), .flush_cnt(flush_b),
        .err_timeout(err[1]));

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid = 1'b0; id_rs1 = 3'd0; id_rs2 = 3'd0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 3'd0; branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic set_hazard();
        id_valid = 1'b1; id_rs1 = 3'd3; id_rs2 = 3'd0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b1; ex_rd = 3'd3;
    endtask

    // Per-cycle comparison of both DUTs against the model, then model advance.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? 1 : 3;
            to  = (d == 0) ? 8 : 5;
            mx  = (d == 0) ? 65535 : 15;
            act_o = {pc_en[d], pc_sel[d], ifid_en[d], ifid_flush[d],
                     idex_en[d], idex_flush[d], exmem_en[d]};
            act_stall = (d == 0) ? int'(stall_a) : int'(stall_b);
            act_flush = (d == 0) ? int'(flush_a) : int'(flush_b);
            if (!rst) begin
                m_err[d] = 1'b0; m_brp[d] = 1'b0; m_busy[d] = 0;
                m_left[d] = 0; m_stall[d] = 0; m_flush[d] = 0;
            end
            hz = id_valid && ex_mem_read &&
                 ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
            br_now = 1'b0;
            exp_o  = 7'b0000000;
            if (rst && !m_err[d] && !mem_busy) begin
                if (branch_taken || m_brp[d]) begin
                    exp_o  = 7'b1111111;
                    br_now = 1'b1;
                end else if (m_left[d] > 0 || hz) begin
                    exp_o = 7'b0000111;
                end else begin
                    exp_o = 7'b1010101;
                end
            end
            chk($sformatf("model_outs[%0d]", d), int'(act_o), int'(exp_o));
            chk($sformatf("model_stall_cnt[%0d]", d), act_stall, m_stall[d]);
            chk($sformatf("model_flush_cnt[%0d]", d), act_flush, m_flush[d]);
            chk($sformatf("model_err[%0d]", d), int'(err[d]), int'(m_err[d]));
            if (rst) begin
                if (!exp_o[6] && m_stall[d] < mx) m_stall[d]++;
                if (br_now && m_flush[d] < mx) m_flush[d]++;
                if (m_err[d]) begin
                    m_busy[d] = m_busy[d];
                end else if (mem_busy) begin
                    m_brp[d] = m_brp[d] | branch_taken;
                    m_busy[d]++;
                    m_left[d] = 0;
                    if (m_busy[d] >= to) m_err[d] = 1'b1;
                end else begin
                    m_busy[d] = 0;
                    if (br_now) begin
                        m_brp[d] = 1'b0;
                        m_left[d] = 0;
                    end else if (m_left[d] > 0) begin
                        m_left[d]--;
                    end else if (hz) begin
                        m_left[d] = lat - 1;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        set_idle();
        @(negedge clk);
        chk("reset_pc_en_a", int'(pc_en[0]), 0);
        chk("reset_exmem_en_b", int'(exmem_en[1]), 0);
        chk("reset_stall_a", int'(stall_a), 0);
        chk("reset_err_b", int'(err[1]), 0);

        next_cycle(); rst = 1'b1; set_idle();
        @(negedge clk);
        chk("run_pc_en_a", int'(pc_en[0]), 1);
        chk("run_ifid_en_b", int'(ifid_en[1]), 1);

        // Load-use on rs1: one bubble for LD_LAT=1, three for LD_LAT=3.
        next_cycle(); set_hazard();
        @(negedge clk);
        chk("ld_pc_en_a", int'(pc_en[0]), 0);
        chk("ld_idex_flush_a", int'(idex_flush[0]), 1);
        chk("ld_pc_en_b", int'(pc_en[1]), 0);
        next_cycle(); set_idle();
        @(negedge clk);
        chk("ld_after_pc_en_a", int'(pc_en[0]), 1);
        chk("ld_after_stall_a", int'(stall_a), 1);
        chk("ld2_pc_en_b", int'(pc_en[1]), 0);
        next_cycle();
        @(negedge clk);
        chk("ld3_pc_en_b", int'(pc_en[1]), 0);
        next_cycle();
        @(negedge clk);
        chk("ld_done_pc_en_b", int'(pc_en[1]), 1);
        chk("ld_done_stall_b", int'(stall_b), 3);

        // rs2 only matters when the instruction reads it.
        next_cycle(); set_idle();
        id_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 3'd5; id_rs1 = 3'd0; id_rs2 = 3'd5;
        @(negedge clk);
        chk("rs2_unused_pc_en_a", int'(pc_en[0]), 1);
        next_cycle(); id_uses_rs2 = 1'b1;
        @(negedge clk);
        chk("rs2_used_pc_en_a", int'(pc_en[0]), 0);
        next_cycle(); set_idle();
        next_cycle();
        @(negedge clk);
        chk("rs2_stall_a", int'(stall_a), 2);

        // Branch with a coincident hazard: flush wins, no stall.
        next_cycle(); set_hazard(); branch_taken = 1'b1;
        @(negedge clk);
        chk("br_pc_sel_a", int'(pc_sel[0]), 1);
        chk("br_ifid_flush_a", int'(ifid_flush[0]), 1);
        chk("br_idex_flush_a", int'(idex_flush[0]), 1);
        chk("br_pc_en_a", int'(pc_en[0]), 1);
        next_cycle(); set_idle();
        @(negedge clk);
        chk("br_flush_cnt_a", int'(flush_a), 1);

        // Four busy cycles with a branch in cycle 2; flush lands on cycle 5.
        for (int k = 1; k <= 4; k++) begin
            next_cycle(); mem_busy = 1'b1; branch_taken = (k == 2);
            @(negedge clk);
            chk($sformatf("busy%0d_pc_en_a", k), int'(pc_en[0]), 0);
            chk($sformatf("busy%0d_exmem_en_a", k), int'(exmem_en[0]), 0);
        end
        next_cycle(); set_idle();
        @(negedge clk);
        chk("busy_exit_pc_sel_a", int'(pc_sel[0]), 1);
        chk("busy_exit_ifid_flush_a", int'(ifid_flush[0]), 1);
        next_cycle();
        @(negedge clk);
        chk("busy_once_pc_sel_a", int'(pc_sel[0]), 0);
        chk("busy_flush_cnt_a", int'(flush_a), 2);

        // Timeout: eight consecutive busy cycles on the MEM_TIMEOUT=8 instance.
        for (int k = 1; k <= 8; k++) begin
            next_cycle(); mem_busy = 1'b1;
            @(negedge clk);
            chk($sformatf("to_busy%0d_err_a", k), int'(err[0]), 0);
        end
        next_cycle(); set_idle();
        @(negedge clk);
        chk("to_err_a", int'(err[0]), 1);
        chk("to_err_pc_en_a", int'(pc_en[0]), 0);
        next_cycle();
        @(negedge clk);
        chk("to_sticky_err_a", int'(err[0]), 1);
        next_cycle(); rst = 1'b0;
        @(negedge clk);
        chk("to_reset_err_a", int'(err[0]), 0);
        next_cycle(); rst = 1'b1;

        // Reset in the middle of a multi-cycle load stall.
        next_cycle(); set_hazard();
        @(negedge clk);
        chk("mid_pc_en_b", int'(pc_en[1]), 0);
        next_cycle();
        @(negedge clk);
        chk("mid2_pc_en_b", int'(pc_en[1]), 0);
        next_cycle(); rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_idex_flush_b", int'(idex_flush[1]), 0);
        chk("mid_rst_idex_en_b", int'(idex_en[1]), 0);
        chk("mid_rst_stall_b", int'(stall_b), 0);
        next_cycle(); rst = 1'b1; set_idle();
        @(negedge clk);
        chk("mid_resume_pc_en_b", int'(pc_en[1]), 1);
        chk("mid_resume_stall_b", int'(stall_b), 0);

        // Randomised traffic with busy bursts, branches and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            rst          = ($urandom_range(0, 149) != 0);
            id_valid     = ($urandom_range(0, 3) != 0);
            id_rs1       = 3'($urandom_range(0, 3));
            id_rs2       = 3'($urandom_range(0, 3));
            id_uses_rs2  = 1'($urandom_range(0, 1));
            ex_mem_read  = 1'($urandom_range(0, 1));
            ex_rd        = 3'($urandom_range(0, 3));
            branch_taken = ($urandom_range(0, 6) == 0);
            if (busy_left > 0) begin
                mem_busy  = 1'b1;
                busy_left--;
            end else if ($urandom_range(0, 9) == 0) begin
                mem_busy  = 1'b1;
                busy_left = $urandom_range(0, 10);
            end else begin
                mem_busy  = 1'b0;
            end
        end
        next_cycle();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
